// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and flag-register bit positions.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_ADC = 3'b001,
      OP_SUB = 3'b010,
      OP_SBC = 3'b011,
      OP_AND = 3'b100,
      OP_OR  = 3'b101,
      OP_XOR = 3'b110,
      OP_CMP = 3'b111
   } alu_op_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_C = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 0;

   typedef logic [3:0] flags_t;

endpackage

// File: rtl/full_adder.sv
// N-bit adder with carry in and carry out; operand inversion is done by the caller.
module full_adder #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum,
   output logic         cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/alu_flag_reg.sv
// Registered ALU with NCVZ flag register and valid/ready handshakes on both sides.
// Optional build macro ALU_SAT_EN enables signed saturation of arithmetic results.
module alu_flag_reg
   import alu_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [2:0]   op,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         upd,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] s,
   output logic         n_flag,
   output logic         c_flag,
   output logic         v_flag,
   output logic         z_flag
);

   // Handshake: a transfer happens on an edge where valid && ready; the output
   // side holds s/out_valid until out_ready, and a slot frees in the same cycle it drains.
   alu_op_e      op_e;
   flags_t       flags;
   flags_t       nxt_flags;
   logic         accept;
   logic         is_sub;
   logic [N-1:0] adder_b;
   logic         adder_cin;
   logic [N-1:0] sum;
   logic         cout;
   logic         arith_v;
   logic         use_logic;
   logic [N-1:0] logic_res;
   logic [N-1:0] res;

`ifdef ALU_SAT_EN
   localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
   localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};
`endif

   assign op_e     = alu_op_e'(op);
   assign in_ready = !rst && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   assign n_flag = flags[FLAG_N];
   assign c_flag = flags[FLAG_C];
   assign v_flag = flags[FLAG_V];
   assign z_flag = flags[FLAG_Z];

   // Carry-in comes from the flag register as it stood before this operation.
   always_comb begin
      is_sub    = (op_e == OP_SUB) || (op_e == OP_SBC) || (op_e == OP_CMP);
      adder_b   = is_sub ? ~b : b;
      adder_cin = 1'b0;
      case (op_e)
         OP_ADC, OP_SBC: adder_cin = flags[FLAG_C];
         OP_SUB, OP_CMP: adder_cin = 1'b1;
         default:        adder_cin = 1'b0;
      endcase
   end

   full_adder #(.N(N)) u_adder (
      .a    (a),
      .b    (adder_b),
      .cin  (adder_cin),
      .sum  (sum),
      .cout (cout)
   );

   assign arith_v = (a[N-1] == adder_b[N-1]) && (sum[N-1] != a[N-1]);

   always_comb begin
      logic_res = '0;
      use_logic = 1'b0;
      case (op_e)
         OP_AND: begin logic_res = a & b; use_logic = 1'b1; end
         OP_OR:  begin logic_res = a | b; use_logic = 1'b1; end
         OP_XOR: begin logic_res = a ^ b; use_logic = 1'b1; end
         default: ;
      endcase

      nxt_flags = '0;
      res       = sum;
      if (use_logic) begin
         res               = logic_res;
         nxt_flags[FLAG_N] = logic_res[N-1];
         nxt_flags[FLAG_Z] = (logic_res == '0);
      end else begin
         nxt_flags[FLAG_N] = sum[N-1];
         nxt_flags[FLAG_C] = cout;
         nxt_flags[FLAG_V] = arith_v;
         nxt_flags[FLAG_Z] = (sum == '0);
         if (op_e == OP_CMP) begin
            res = a;
         end
`ifdef ALU_SAT_EN
         // On overflow the true result's sign is the (shared) operand sign.
         else if (arith_v) begin
            res = a[N-1] ? SAT_MIN : SAT_MAX;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         s         <= '0;
         flags     <= '0;
      end else if (accept) begin
         out_valid <= 1'b1;
         s         <= res;
         if (upd) begin
            flags <= nxt_flags;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/alu_flag_reg.md
ALU_FLAG_REG -- requirements
Module: alu_flag_reg

Interface
REQ-001 SHALL have parameter: N, default 4, operand/result width in bits (N >= 2).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: in_valid  input  1  operation request valid.
REQ-005 SHALL have port: in_ready  output  1  block can accept an operation this cycle.
REQ-006 SHALL have port: op  input  3  opcode (see REQ-012).
REQ-007 SHALL have port: a, b  input  N each  operands, two's complement.
REQ-008 SHALL have port: upd  input  1  when 1, the accepted operation writes the flag register.
REQ-009 SHALL have port: out_valid  output  1  registered result valid.
REQ-010 SHALL have port: out_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL have ports: s  output  N  registered result; n_flag, c_flag, v_flag, z_flag  output  1 each  registered flag register.

Function
REQ-012 SHALL decode op: 000 ADD a+b; 001 ADC a+b+c_flag; 010 SUB a+~b+1; 011 SBC a+~b+c_flag; 100 AND; 101 OR; 110 XOR; 111 CMP (flags as SUB, s = a).
REQ-013 SHALL accept an operation when in_valid && in_ready; in_ready = !rst && (!out_valid || out_ready).
REQ-014 SHALL present the result of an accepted operation on s with out_valid=1 exactly one cycle after acceptance (latency 1).
REQ-015 SHALL hold s and out_valid stable while out_valid && !out_ready; out_valid clears after a handshake with no new acceptance.
REQ-016 SHALL sustain one operation per cycle when out_ready is held 1 (accept and drain in the same cycle).
REQ-017 SHALL compute arithmetic flags from the N-bit sum: N = s[N-1]; Z = (s == 0); C = carry-out of bit N-1 (for SUB/SBC/CMP C=1 means no borrow); V = operand-to-adder signs equal and sum sign differs.
REQ-018 SHALL set, for logical ops, N and Z from the result, C = 0, V = 0.
REQ-019 SHALL write all four flags at acceptance only if upd=1; upd=0 leaves flags unchanged; flags change in the same edge that loads s.
REQ-020 SHALL have ADC/SBC use the flag register value before the current operation's update; back-to-back ADC sees the C written by the previous accepted op.
REQ-021 SHALL wrap results modulo 2^N (e.g. N=4: 0111+0001 = 1000, V=1).
REQ-022 SHALL ignore op, a, b, upd when no acceptance occurs.

Reset
REQ-023 SHALL, while rst=1 at a clock edge: out_valid=0, s=0, n_flag=c_flag=v_flag=z_flag=0, in_ready=0.
REQ-024 SHALL discard any pending unconsumed result on reset mid-operation; no result appears after rst deasserts until a new acceptance.
REQ-025 SHALL have in_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-026 SHALL, with ALU_SAT_EN defined, saturate ADD/ADC/SUB/SBC results when V=1: to 2^(N-1)-1 if the true result is positive, else -2^(N-1); flags remain those of the unsaturated sum (V=1 reported).
REQ-027 SHALL, without ALU_SAT_EN, wrap per REQ-021 with no saturation logic present; CMP and logical ops are identical in both builds.

Structure
REQ-028 SHALL place opcode constants (OP_ADD..OP_CMP) and flag bit indices (N=3, C=2, V=1, Z=0) in shared package alu_pkg.
REQ-029 SHALL instantiate existing full_adder #(N) as the single sub-module for the add/subtract path (b inverted and carry-in selected outside it).

Verification (N=4)
REQ-030 SHALL cover: reset, then ADD a=0,b=0,upd=1 -> next cycle s=0000, NCVZ=0001, out_valid=1.
REQ-031 SHALL cover: ADD a=1001,b=1001 (-7+-7) upd=1 -> s=0010, NCVZ=0110; then ADD a=0011,b=1001 -> s=1100, NCVZ=1000.
REQ-032 SHALL cover: ADD a=1111,b=0001 upd=1 -> C=1; next ADC a=0000,b=0000 -> s=0001; repeat with upd=0 on first op -> ADC s=0000.
REQ-033 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, s/out_valid held, flags unchanged; out_ready=1 -> drain and accept same cycle.
REQ-034 SHALL cover: CMP a=0101,b=0101 -> s=0101, NCVZ=0101; AND a=1100,b=1010 -> s=1000, NCVZ=1000.
REQ-035 SHALL cover: rst asserted while out_valid=1,out_ready=0 -> out_valid=0, flags=0; ALU_SAT_EN build: ADD 0111+0001 -> s=0111, V=1.
